// File: rtl/traffic_pkg.sv
// Shared types and constants for the intersection controllers and the timer arbiter.
package traffic_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StRun  = 2'd2
  } arb_state_e;

  localparam int unsigned TIMER_W_DEFAULT = 8;

  // A duration value V gives V+1 countdown cycles.
  localparam int unsigned GREEN_45 = 44;
  localparam int unsigned YELLOW_5 = 4;
  localparam int unsigned ALLRED_1 = 0;
  localparam int unsigned GREEN_15 = 14;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after i_ptr, with wrap.
module rr_pick #(
  parameter int unsigned N    = 3,
  parameter int unsigned PtrW = 2
) (
  input  logic [N-1:0]    i_req,
  input  logic [PtrW-1:0] i_ptr,
  output logic [N-1:0]    o_onehot,
  output logic            o_valid
);

  logic [PtrW:0]    w_shift;
  logic [2*N-1:0]   w_rot_dbl;
  logic [2*N-1:0]   w_back_dbl;
  logic [N-1:0]     w_rot;
  logic [N-1:0]     w_rot_oh;
  logic             w_unused;

  // Rotate so that requester ptr+1 sits at bit 0, isolate the lowest set bit, rotate back.
  assign w_shift    = {1'b0, i_ptr} + {{PtrW{1'b0}}, 1'b1};
  assign w_rot_dbl  = {i_req, i_req} >> w_shift;
  assign w_rot      = w_rot_dbl[N-1:0];
  assign w_rot_oh   = w_rot & (~w_rot + {{(N-1){1'b0}}, 1'b1});
  assign w_back_dbl = {w_rot_oh, w_rot_oh} << w_shift;
  assign o_onehot   = w_back_dbl[2*N-1:N];
  assign o_valid    = |i_req;

  assign w_unused = ^{w_rot_dbl[2*N-1:N], w_back_dbl[N-1:0]};

endmodule

// File: rtl/timer_arbiter.sv
// Round-robin owner of the shared countdown counter: grants, loads the duration,
// runs the countdown and pulses done to the owner on expiry.
module timer_arbiter
  import traffic_pkg::*;
#(
  parameter int unsigned N       = 3,
  parameter int unsigned TIMER_W = TIMER_W_DEFAULT
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [N-1:0]         req,
  input  logic [N*TIMER_W-1:0] req_value,
  output logic [N-1:0]         grant,
  output logic [N-1:0]         done,
  output logic                 busy,
  output logic                 load,
  output logic [TIMER_W-1:0]   value,
  output logic                 decr,
  input  logic                 timeup
);

  localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1;

  arb_state_e           r_state;
  logic [N-1:0]         r_grant;
  logic [N-1:0]         r_done;
  logic [TIMER_W-1:0]   r_value;
  logic [PtrW-1:0]      r_ptr;

  logic [N-1:0]         w_pick;
  logic                 w_valid;
  logic [PtrW-1:0]      w_win_idx;
  logic [TIMER_W-1:0]   w_win_value;
  logic                 w_owner_req;

  rr_pick #(
    .N    (N),
    .PtrW (PtrW)
  ) u_rr_pick (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .o_onehot (w_pick),
    .o_valid  (w_valid)
  );

  always_comb begin
    w_win_idx   = '0;
    w_win_value = '0;
    for (int i = 0; i < N; i++) begin
      if (w_pick[i]) begin
        w_win_idx   = PtrW'(i);
        w_win_value = req_value[i*TIMER_W +: TIMER_W];
      end
    end
  end

  assign w_owner_req = |(req & r_grant);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state <= StIdle;
      r_grant <= '0;
      r_done  <= '0;
      r_value <= '0;
      r_ptr   <= PtrW'(N - 1);
    end else begin
      r_done <= '0;
      case (r_state)
        StIdle: begin
          // The done cycle is a turnaround: no arbitration while done is high.
          if (r_done == '0 && w_valid) begin
            r_grant <= w_pick;
            r_value <= w_win_value;
            r_ptr   <= w_win_idx;
            r_state <= StLoad;
          end
        end
        StLoad: begin
          if (!w_owner_req) begin
            r_grant <= '0;
            r_state <= StIdle;
          end else begin
            r_state <= StRun;
          end
        end
        StRun: begin
          if (!w_owner_req) begin
            r_grant <= '0;
            r_state <= StIdle;
          end else if (timeup) begin
            r_done  <= r_grant;
            r_grant <= '0;
            r_state <= StIdle;
          end
        end
        default: begin
          r_grant <= '0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign grant = r_grant;
  assign done  = r_done;
  assign value = r_value;
  assign busy  = (r_state != StIdle);
  // An owner that has already let go in the load cycle never gets the counter loaded.
  assign load  = (r_state == StLoad) && w_owner_req;
  assign decr  = (r_state == StRun) && !timeup;

endmodule
